// File: rtl/clock_pkg.sv
// Shared types and limits for the cuckoo clock timekeeping stage.
// Mode encodings and BCD field maximums.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2
  } mode_e;

  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HOUR_MAX = 8'h23;

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter with clear and increment.
// Wraps to 00 after {MAX_TENS,MAX_ONES} and flags the wrap on carry.
module bcd_mod_counter #(
  parameter logic [3:0] MAX_TENS = 4'd5,
  parameter logic [3:0] MAX_ONES = 4'd9
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] value,
  output logic       carry
);

  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       at_max;

  assign at_max = (tens_q == MAX_TENS) && (ones_q == MAX_ONES);
  assign carry  = inc && !clr && at_max;
  assign value  = {tens_q, ones_q};

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (clr) begin
      tens_d = 4'd0;
      ones_d = 4'd0;
    end else if (inc) begin
      if (at_max) begin
        tens_d = 4'd0;
        ones_d = 4'd0;
      end else if (ones_q == 4'd9) begin
        tens_d = tens_q + 4'd1;
        ones_d = 4'd0;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

endmodule

// File: rtl/clock_time_bcd.sv
// Timekeeping stage: 1 s prescaler, HH:MM:SS in BCD, set modes,
// digit flashing and the hourly cuckoo pulse for the FND controller.
module clock_time_bcd
  import clock_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic        btn_clr,
  output logic [15:0] value,
  output logic [3:0]  blank,
  output logic [1:0]  mode,
  output logic        sec_half,
  output logic        cuckoo
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  mode_e         mode_q, mode_d;
  logic          sec_half_q, sec_half_d;
  logic [3:0]    blank_q, blank_d;
  logic          cuckoo_q, cuckoo_d;

  logic       tick, run_tick, restart;
  logic       sec_inc, min_inc, hour_inc, sec_clr;
  logic       sec_carry, min_carry, hour_carry;
  logic [7:0] sec_v, min_v, hour_v;

  assign tick     = (cnt_q == CW'(TICK_DIV - 1));
  assign run_tick = tick && (mode_q == MODE_RUN);
  assign restart  = btn_mode && (mode_q == MODE_SET_MIN);

  assign sec_clr  = btn_clr || restart;
  assign sec_inc  = run_tick;
  assign min_inc  = (run_tick && sec_carry) ||
                    (btn_inc && mode_q == MODE_SET_MIN);
  assign hour_inc = (run_tick && min_carry) ||
                    (btn_inc && mode_q == MODE_SET_HOUR);

  bcd_mod_counter #(
    .MAX_TENS(SEC_MAX[7:4]),
    .MAX_ONES(SEC_MAX[3:0])
  ) u_sec (
    .clk    (clk),
    .reset_p(reset_p),
    .clr    (sec_clr),
    .inc    (sec_inc),
    .value  (sec_v),
    .carry  (sec_carry)
  );

  bcd_mod_counter #(
    .MAX_TENS(MIN_MAX[7:4]),
    .MAX_ONES(MIN_MAX[3:0])
  ) u_min (
    .clk    (clk),
    .reset_p(reset_p),
    .clr    (btn_clr),
    .inc    (min_inc),
    .value  (min_v),
    .carry  (min_carry)
  );

  bcd_mod_counter #(
    .MAX_TENS(HOUR_MAX[7:4]),
    .MAX_ONES(HOUR_MAX[3:0])
  ) u_hour (
    .clk    (clk),
    .reset_p(reset_p),
    .clr    (btn_clr),
    .inc    (hour_inc),
    .value  (hour_v),
    .carry  (hour_carry)
  );

  always_comb begin
    mode_d = mode_q;
    unique case (mode_q)
      MODE_RUN:      if (btn_mode) mode_d = MODE_SET_HOUR;
      MODE_SET_HOUR: if (btn_mode) mode_d = MODE_SET_MIN;
      MODE_SET_MIN:  if (btn_mode) mode_d = MODE_RUN;
      default:       mode_d = MODE_RUN;
    endcase
  end

  // Leaving SET_MIN restarts the second so the new minute is exact.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (sec_clr || tick) cnt_d = '0;
  end

  // sec_half and blank track the values the registers take this edge.
  always_comb begin
    sec_half_d = (cnt_d < CW'(TICK_DIV / 2));
    blank_d    = 4'b0000;
    unique case (mode_d)
      MODE_SET_HOUR: if (!sec_half_d) blank_d = 4'b1100;
      MODE_SET_MIN:  if (!sec_half_d) blank_d = 4'b0011;
      default:       blank_d = 4'b0000;
    endcase
    cuckoo_d = run_tick && (min_carry || hour_carry);
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      cnt_q      <= '0;
      mode_q     <= MODE_RUN;
      sec_half_q <= 1'b1;
      blank_q    <= 4'b0000;
      cuckoo_q   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      sec_half_q <= sec_half_d;
      blank_q    <= blank_d;
      cuckoo_q   <= cuckoo_d;
    end
  end

  assign value    = {hour_v, min_v};
  assign blank    = blank_q;
  assign mode     = mode_q;
  assign sec_half = sec_half_q;
  assign cuckoo   = cuckoo_q;

endmodule

// File: tb/tb_clock_time_bcd.sv
// Directed bench for clock_time_bcd with a cycle model and scoreboard.
// Observed word: {value, blank, mode, sec_half, cuckoo}.
module tb_clock_time_bcd;

  logic        clk = 1'b0;
  logic        reset_p;
  logic        btn_mode, btn_inc, btn_clr;
  logic [15:0] value;
  logic [3:0]  blank;
  logic [1:0]  mode;
  logic        sec_half;
  logic        cuckoo;

  int n_chk  = 0;
  int n_fail = 0;

  int mh, mm, ms, mph, mmode;
  logic mcuck;
  int ncuck;
  logic [15:0] cuck_val;

  logic [23:0] sb[$];

  always #5 clk = ~clk;

  clock_time_bcd #(.TICK_DIV(4)) dut (
    .clk     (clk),
    .reset_p (reset_p),
    .btn_mode(btn_mode),
    .btn_inc (btn_inc),
    .btn_clr (btn_clr),
    .value   (value),
    .blank   (blank),
    .mode    (mode),
    .sec_half(sec_half),
    .cuckoo  (cuckoo)
  );

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [23:0] obs();
    return {value, blank, mode, sec_half, cuckoo};
  endfunction

  function automatic logic [23:0] model_out();
    logic [3:0] b;
    logic sh;
    sh = (mph < 2);
    b = 4'b0000;
    if (mmode == 1 && !sh) b = 4'b1100;
    if (mmode == 2 && !sh) b = 4'b0011;
    return {bcd(mh), bcd(mm), b, 2'(mmode), sh, mcuck};
  endfunction

  task automatic chk(input string tag, input logic [23:0] o,
                     input logic [23:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic model_reset();
    mh = 0; mm = 0; ms = 0; mph = 0; mmode = 0; mcuck = 1'b0;
    sb.delete();
  endtask

  task automatic model_edge(input logic bm, input logic bi,
                            input logic bc);
    logic tk, rs;
    tk = (mph == 3);
    rs = (mmode == 2) && bm;
    mcuck = 1'b0;
    if (bc) begin
      mh = 0; mm = 0; ms = 0;
    end else if (mmode == 1 && bi) begin
      mh = (mh + 1) % 24;
    end else if (mmode == 2 && bi) begin
      mm = (mm + 1) % 60;
    end else if (mmode == 0 && tk) begin
      ms++;
      if (ms == 60) begin
        ms = 0;
        mm++;
        if (mm == 60) begin
          mm = 0;
          mcuck = 1'b1;
          mh = (mh + 1) % 24;
        end
      end
    end
    if (rs) ms = 0;
    mph = (bc || rs || tk) ? 0 : mph + 1;
    if (bm) mmode = (mmode == 0) ? 1 : (mmode == 1) ? 2 : 0;
  endtask

  // One clock: drive buttons, push expectation, compare after the edge.
  task automatic cyc(input logic bm, input logic bi, input logic bc);
    logic [23:0] e;
    btn_mode = bm;
    btn_inc  = bi;
    btn_clr  = bc;
    model_edge(bm, bi, bc);
    sb.push_back(model_out());
    @(negedge clk);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    btn_clr  = 1'b0;
    e = sb.pop_front();
    chk("cycle", obs(), e);
    if (cuckoo) begin
      ncuck++;
      cuck_val = value;
    end
  endtask

  initial begin
    reset_p  = 1'b1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    btn_clr  = 1'b0;
    ncuck    = 0;
    cuck_val = 16'hffff;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_state", obs(), {16'h0000, 4'h0, 2'd0, 1'b1, 1'b0});
    reset_p = 1'b0;

    // Reset and count
    repeat (240) cyc(0, 0, 0);
    chk("t1_value", {8'h0, value}, 24'h000001);
    chk("t1_mode", {22'h0, mode}, 24'h0);
    chk("t1_no_cuckoo", 24'(ncuck), 24'd0);

    // Hour rollover from 23:59
    cyc(1, 0, 0);
    repeat (23) cyc(0, 1, 0);
    cyc(1, 0, 0);
    repeat (58) cyc(0, 1, 0);
    cyc(1, 0, 0);
    chk("t2_set", {8'h0, value}, 24'h002359);
    ncuck = 0;
    repeat (240) cyc(0, 0, 0);
    chk("t2_value", {8'h0, value}, 24'h000000);
    chk("t2_cuckoo_once", 24'(ncuck), 24'd1);
    chk("t2_cuckoo_val", {8'h0, cuck_val}, 24'h000000);

    // Set-mode wrap and flashing
    cyc(0, 0, 1);
    cyc(1, 0, 0);
    repeat (25) cyc(0, 1, 0);
    chk("t3_hour", {8'h0, value}, 24'h000100);
    chk("t3_blank_off", {20'h0, blank}, 24'h00000c);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("t3_blank_on", {20'h0, blank}, 24'h000000);
    cyc(1, 0, 0);
    repeat (61) cyc(0, 1, 0);
    chk("t3_min", {8'h0, value}, 24'h000101);

    // clr beats inc in SET_MIN at 12:34
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    repeat (11) cyc(0, 1, 0);
    cyc(1, 0, 0);
    repeat (33) cyc(0, 1, 0);
    chk("t4_set", {8'h0, value}, 24'h001234);
    cyc(0, 1, 1);
    chk("t4_clr", {6'h0, value, mode}, {6'h0, 16'h0000, 2'd2});

    // mode + inc together in SET_HOUR at 05:10
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    repeat (5) cyc(0, 1, 0);
    cyc(1, 0, 0);
    repeat (10) cyc(0, 1, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    chk("t4_pre", {6'h0, value, mode}, {6'h0, 16'h0510, 2'd1});
    cyc(1, 1, 0);
    chk("t4_mode_inc", {6'h0, value, mode}, {6'h0, 16'h0610, 2'd2});

    // Seconds restart on SET_MIN -> RUN
    repeat (3) cyc(0, 0, 0);
    cyc(1, 0, 0);
    repeat (239) cyc(0, 0, 0);
    chk("t5_before", {8'h0, value}, 24'h000610);
    cyc(0, 0, 0);
    chk("t5_after", {8'h0, value}, 24'h000611);

    // Async reset mid-set at 08:45
    cyc(1, 0, 0);
    repeat (2) cyc(0, 1, 0);
    cyc(1, 0, 0);
    repeat (34) cyc(0, 1, 0);
    chk("t6_set", {6'h0, value, mode}, {6'h0, 16'h0845, 2'd2});
    #2;
    reset_p = 1'b1;
    #1;
    chk("t6_async", obs(), {16'h0000, 4'h0, 2'd0, 1'b1, 1'b0});
    model_reset();
    @(negedge clk);
    reset_p = 1'b0;
    repeat (3) cyc(0, 0, 0);
    chk("t6_no_tick", {8'h0, value}, 24'h000000);
    repeat (237) cyc(0, 0, 0);
    chk("t6_count", {8'h0, value}, 24'h000001);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
